// File: rtl/wb_arbiter.sv
// wb_arbiter: per-source result FIFOs arbitrated onto NUM_WP registered register-file write ports.
// Build option: define WB_RR_ARB_EN for round-robin arbitration; otherwise fixed priority, lowest index first.
module wb_arbiter #(
    parameter int N_SRC      = 3,
    parameter int NUM_WP     = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [N_SRC-1:0]       src_valid_i,
    output logic [N_SRC-1:0]       src_ready_o,
    input  logic [N_SRC-1:0]       src_we_i,
    input  logic [N_SRC*5-1:0]     src_rd_i,
    input  logic [N_SRC*XLEN-1:0]  src_data_i,
    output logic [NUM_WP-1:0]      wb_en_o,
    output logic [NUM_WP*5-1:0]    wb_addr_o,
    output logic [NUM_WP*XLEN-1:0] wb_data_o,
    output logic [NUM_WP-1:0]      wb_valid_o,
    output logic                   idle_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + 5 + XLEN;
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [EW-1:0]     mem_q    [N_SRC][FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q [N_SRC];
    logic [AW:0]       rd_ptr_q [N_SRC];
    logic [AW:0]       cnt_q    [N_SRC];
    logic [N_SRC-1:0]  empty, full, push, pop;
    logic [N_SRC-1:0]  head_we;
    logic [4:0]        head_rd   [N_SRC];
    logic [XLEN-1:0]   head_data [N_SRC];

    logic [NUM_WP-1:0] cand_vld, issue;
    logic [SW-1:0]     cand_idx [NUM_WP];
    logic [SW-1:0]     search_base;
    logic [SW:0]       scan;
    logic [SW-1:0]     idx;

    logic [NUM_WP-1:0]      wb_valid_q, wb_en_q;
    logic [NUM_WP*5-1:0]    wb_addr_q;
    logic [NUM_WP*XLEN-1:0] wb_data_q;

    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            empty[s] = (cnt_q[s] == '0);
            full[s]  = (cnt_q[s] == (AW+1)'(FIFO_DEPTH));
            {head_we[s], head_rd[s], head_data[s]} = mem_q[s][rd_ptr_q[s][AW-1:0]];
        end
    end

    // Ready looks only at registered occupancy, so a full FIFO stays closed even while it is popped.
    assign src_ready_o = ~full & {N_SRC{~flush_i}};
    assign push        = src_valid_i & src_ready_o;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        cand_vld = '0;
        for (int w = 0; w < NUM_WP; w++) cand_idx[w] = '0;
        scan = '0;
        idx  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            scan = {1'b0, search_base} + (SW+1)'(k);
            if (scan >= (SW+1)'(N_SRC)) scan = scan - (SW+1)'(N_SRC);
            idx = scan[SW-1:0];
            if (!empty[idx]) begin
                if (!cand_vld[0]) begin
                    cand_vld[0] = 1'b1;
                    cand_idx[0] = idx;
                end else if (NUM_WP > 1 && !cand_vld[NUM_WP-1]) begin
                    cand_vld[NUM_WP-1] = 1'b1;
                    cand_idx[NUM_WP-1] = idx;
                end
            end
        end
        issue = flush_i ? '0 : cand_vld;
        // Two writes to the same architectural register in one cycle: the second waits, unreplaced.
        if (NUM_WP > 1 && cand_vld[NUM_WP-1] &&
            head_we[cand_idx[0]] && head_we[cand_idx[NUM_WP-1]] &&
            head_rd[cand_idx[0]] != 5'd0 &&
            head_rd[cand_idx[0]] == head_rd[cand_idx[NUM_WP-1]])
            issue[NUM_WP-1] = 1'b0;
    end

    always_comb begin
        pop = '0;
        for (int w = 0; w < NUM_WP; w++)
            for (int s = 0; s < N_SRC; s++)
                if (issue[w] && cand_idx[w] == SW'(s)) pop[s] = 1'b1;
    end

    // NOTE: entry storage is not reset; the occupancy counters alone define which entries are live.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < N_SRC; s++)
            if (push[s])
                mem_q[s][wr_ptr_q[s][AW-1:0]] <= {src_we_i[s], src_rd_i[s*5 +: 5], src_data_i[s*XLEN +: XLEN]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < N_SRC; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
        end else begin
            for (int s = 0; s < N_SRC; s++) begin
                if (flush_i) begin
                    wr_ptr_q[s] <= '0;
                    rd_ptr_q[s] <= '0;
                    cnt_q[s]    <= '0;
                end else begin
                    if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + 1'b1;
                    if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
                    if (push[s] && !pop[s])      cnt_q[s] <= cnt_q[s] + 1'b1;
                    else if (!push[s] && pop[s]) cnt_q[s] <= cnt_q[s] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q <= '0;
            wb_en_q    <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            for (int w = 0; w < NUM_WP; w++) begin
                if (issue[w]) begin
                    wb_valid_q[w]              <= 1'b1;
                    wb_en_q[w]                 <= head_we[cand_idx[w]] && (head_rd[cand_idx[w]] != 5'd0);
                    wb_addr_q[w*5 +: 5]        <= head_rd[cand_idx[w]];
                    wb_data_q[w*XLEN +: XLEN]  <= head_data[cand_idx[w]];
                end else begin
                    wb_valid_q[w] <= 1'b0;
                    wb_en_q[w]    <= 1'b0;
                end
            end
        end
    end

`ifdef WB_RR_ARB_EN
    logic [SW-1:0] rr_ptr_q;
    logic [SW-1:0] rr_last;

    assign search_base = rr_ptr_q;
    assign rr_last     = issue[NUM_WP-1] ? cand_idx[NUM_WP-1] : cand_idx[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     rr_ptr_q <= '0;
        else if (|issue) rr_ptr_q <= (rr_last == SW'(N_SRC-1)) ? '0 : rr_last + 1'b1;
    end
`else
    assign search_base = '0;
`endif

    assign wb_valid_o = wb_valid_q;
    assign wb_en_o    = wb_en_q;
    assign wb_addr_o  = wb_addr_q;
    assign wb_data_o  = wb_data_q;
    assign idle_o     = (&empty) && !(|wb_valid_q);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: one single-port and one dual-port instance.
// Expected arbitration order follows WB_RR_ARB_EN when the bench is built with it.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Single write port instance.
    logic [2:0]  a_valid = '0, a_we = '0, a_ready;
    logic [14:0] a_rd = '0;
    logic [95:0] a_data = '0;
    logic        a_en, a_wbv, a_idle;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata;

    wb_arbiter #(.N_SRC(3), .NUM_WP(1), .FIFO_DEPTH(2), .XLEN(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .src_valid_i(a_valid), .src_ready_o(a_ready), .src_we_i(a_we),
        .src_rd_i(a_rd), .src_data_i(a_data),
        .wb_en_o(a_en), .wb_addr_o(a_addr), .wb_data_o(a_wdata),
        .wb_valid_o(a_wbv), .idle_o(a_idle)
    );

    // Dual write port instance.
    logic [2:0]  b_valid = '0, b_we = '0, b_ready;
    logic [14:0] b_rd = '0;
    logic [95:0] b_data = '0;
    logic [1:0]  b_en, b_wbv;
    logic        b_idle;
    logic [9:0]  b_addr;
    logic [63:0] b_wdata;

    wb_arbiter #(.N_SRC(3), .NUM_WP(2), .FIFO_DEPTH(2), .XLEN(32)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
        .src_valid_i(b_valid), .src_ready_o(b_ready), .src_we_i(b_we),
        .src_rd_i(b_rd), .src_data_i(b_data),
        .wb_en_o(b_en), .wb_addr_o(b_addr), .wb_data_o(b_wdata),
        .wb_valid_o(b_wbv), .idle_o(b_idle)
    );

`ifdef WB_RR_ARB_EN
    int ord_s [6] = '{0, 1, 2, 0, 1, 2};
    int ord_q [6] = '{0, 0, 0, 1, 1, 1};
`else
    int ord_s [6] = '{0, 0, 1, 1, 2, 2};
    int ord_q [6] = '{0, 1, 0, 1, 0, 1};
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic v, input logic en,
                           input logic [4:0] addr, input logic [31:0] data);
        check({tag, ".valid"}, 64'(a_wbv), 64'(v));
        check({tag, ".en"},    64'(a_en),  64'(en));
        check({tag, ".addr"},  64'(a_addr),  64'(addr));
        check({tag, ".data"},  64'(a_wdata), 64'(data));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] s, input logic v, input logic we,
                           input logic [4:0] rd, input logic [31:0] d);
        a_valid[s]        = v;
        a_we[s]           = we;
        a_rd[s*5 +: 5]    = rd;
        a_data[s*32 +: 32] = d;
    endtask

    task automatic drive_b(input logic [1:0] s, input logic v, input logic we,
                           input logic [4:0] rd, input logic [31:0] d);
        b_valid[s]        = v;
        b_we[s]           = we;
        b_rd[s*5 +: 5]    = rd;
        b_data[s*32 +: 32] = d;
    endtask

    initial begin
        // Reset state.
        #12;
        rst_n = 1'b1;
        #1;
        check_a("reset", 1'b0, 1'b0, 5'd0, 32'd0);
        check("reset.idle",  64'(a_idle),  64'd1);
        check("reset.ready", 64'(a_ready), 64'h7);
        check("reset2.valid", 64'(b_wbv), 64'd0);
        check("reset2.idle",  64'(b_idle), 64'd1);
        tick();

        // Three sources pushed together twice: backpressure and arbitration order.
        for (int s = 0; s < 3; s++) drive_a(2'(s), 1'b1, 1'b1, 5'(8 + s), 32'hA000 + 32'(s * 16));
        tick();
        for (int s = 0; s < 3; s++) drive_a(2'(s), 1'b1, 1'b1, 5'(8 + s), 32'hA000 + 32'(s * 16 + 1));
        tick();
        a_valid = '0;
        check("bp.ready", 64'(a_ready), 64'h1);
        check_a("arb0", 1'b1, 1'b1, 5'(8 + ord_s[0]), 32'hA000 + 32'(ord_s[0] * 16 + ord_q[0]));
        for (int i = 1; i < 6; i++) begin
            tick();
            check_a($sformatf("arb%0d", i), 1'b1, 1'b1, 5'(8 + ord_s[i]),
                    32'hA000 + 32'(ord_s[i] * 16 + ord_q[i]));
        end
        tick();
        check("arb.drain.valid", 64'(a_wbv), 64'd0);
        check("arb.drain.idle",  64'(a_idle), 64'd1);

        // Single entry latency.
        drive_a(2'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        a_valid = '0;
        check("lat.e0.valid", 64'(a_wbv), 64'd0);
        check("lat.e0.idle",  64'(a_idle), 64'd0);
        tick();
        check_a("lat.e1", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_a("lat.e2", 1'b0, 1'b0, 5'd5, 32'hDEADBEEF);

        // x0 destination and no-write entries retire without enabling the write.
        drive_a(2'd1, 1'b1, 1'b1, 5'd0, 32'h11);
        tick();
        drive_a(2'd1, 1'b1, 1'b0, 5'd7, 32'h22);
        tick();
        a_valid = '0;
        check_a("x0", 1'b1, 1'b0, 5'd0, 32'h11);
        tick();
        check_a("nowe", 1'b1, 1'b0, 5'd7, 32'h22);
        tick();
        check("nowe.after", 64'(a_wbv), 64'd0);

        // One source streaming every cycle.
        for (int i = 0; i < 4; i++) begin
            drive_a(2'd2, 1'b1, 1'b1, 5'd3, 32'h100 + 32'(i));
            tick();
            check($sformatf("stream%0d.ready", i), 64'(a_ready[2]), 64'd1);
            if (i > 0) check_a($sformatf("stream%0d", i), 1'b1, 1'b1, 5'd3, 32'h100 + 32'(i - 1));
        end
        a_valid = '0;
        tick();
        check_a("stream4", 1'b1, 1'b1, 5'd3, 32'h103);
        tick();
        check("stream.after", 64'(a_wbv), 64'd0);

        // Flush with full FIFOs and pushes still offered.
        for (int s = 0; s < 3; s++) drive_a(2'(s), 1'b1, 1'b1, 5'd4, 32'hF0 + 32'(s));
        tick();
        tick();
        check("flush.pre.valid", 64'(a_wbv), 64'd1);
        flush = 1'b1;
        #1;
        check("flush.ready", 64'(a_ready), 64'h0);
        tick();
        flush = 1'b0;
        a_valid = '0;
        #1;
        check("flush.valid", 64'(a_wbv), 64'd0);
        check("flush.en",    64'(a_en),  64'd0);
        check("flush.idle",  64'(a_idle), 64'd1);
        check("flush.ready2", 64'(a_ready), 64'h7);
        tick();
        check("flush.after.valid", 64'(a_wbv), 64'd0);
        check("flush.after.idle",  64'(a_idle), 64'd1);

        // Dual port: same destination conflict, then two independent writes.
        drive_b(2'd0, 1'b1, 1'b1, 5'd9, 32'h900);
        drive_b(2'd1, 1'b1, 1'b1, 5'd9, 32'h901);
        tick();
        b_valid = '0;
        tick();
        check("conf.e1.valid", 64'(b_wbv), 64'h1);
        check("conf.e1.addr",  64'(b_addr[4:0]), 64'd9);
        check("conf.e1.data",  64'(b_wdata[31:0]), 64'h900);
        tick();
        check("conf.e2.valid", 64'(b_wbv), 64'h1);
        check("conf.e2.data",  64'(b_wdata[31:0]), 64'h901);
        tick();
        check("conf.e3.valid", 64'(b_wbv), 64'h0);
        drive_b(2'd0, 1'b1, 1'b1, 5'd3, 32'h300);
        drive_b(2'd2, 1'b1, 1'b1, 5'd4, 32'h400);
        tick();
        b_valid = '0;
        tick();
        check("dual.valid", 64'(b_wbv), 64'h3);
        check("dual.en",    64'(b_en),  64'h3);
`ifdef WB_RR_ARB_EN
        check("dual.addr", 64'(b_addr),  64'({5'd3, 5'd4}));
        check("dual.data", b_wdata,      {32'h300, 32'h400});
`else
        check("dual.addr", 64'(b_addr),  64'({5'd4, 5'd3}));
        check("dual.data", b_wdata,      {32'h400, 32'h300});
`endif
        tick();
        check("dual.after.valid", 64'(b_wbv), 64'h0);
        check("dual.after.idle",  64'(b_idle), 64'd1);

        // Asynchronous reset in the middle of a stream.
        for (int s = 0; s < 3; s++) drive_a(2'(s), 1'b1, 1'b1, 5'd6, 32'h60 + 32'(s));
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_a("rst.async", 1'b0, 1'b0, 5'd0, 32'd0);
        check("rst.idle", 64'(a_idle), 64'd1);
        a_valid = '0;
        #3;
        rst_n = 1'b1;
        tick();
        check("rst.ready", 64'(a_ready), 64'h7);
        check("rst.valid", 64'(a_wbv), 64'd0);
        check("rst.idle2", 64'(a_idle), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
